// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle controller: state encoding,
// the recognised opcodes and the ALUOp encodings seen by the ALU control.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5,
    ST_ERR    = 3'd6
  } mc_state_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_HALT   = 7'b0000001;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_ARITH = 2'b10;
  localparam logic [1:0] ALUOP_UTYPE = 2'b11;

  // True for every opcode that proceeds from DECODE into EXEC.
  function automatic logic is_exec_op(input logic [6:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_OPIMM, OP_LUI, OP_JAL, OP_JALR: ok = 1'b1;
      default:                           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state counter for the multi-cycle controller. Counts cycles in
// which a request is outstanding without completion, clears on completion or
// on any controller state change, and saturates at 8 bits.
module mc_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_mem_req,
  input  logic i_mem_ready,
  input  logic i_state_chg,
  output logic o_timeout
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  logic [7:0] r_wait_cnt;
  logic       w_done;

  // A strobe only counts as completion while a request is outstanding.
  assign w_done = i_mem_req && i_mem_ready;

  // Wait-cycle counter with saturation at 255.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if (w_done || i_state_chg) begin
      r_wait_cnt <= '0;
    end else if (i_mem_req && (r_wait_cnt != 8'hFF)) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // Not gated by i_mem_req: the controller only consults this in its memory
  // states, and gating here would close a combinational loop through mem_req.
  // A ready strobe in the same cycle wins over the timeout.
  assign o_timeout = !i_mem_ready && (r_wait_cnt >= TIMEOUT_CNT);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle processor control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// All outputs are combinational decodes of the state register and the
// latched opcode, and are forced low while reset is asserted.
// Optional performance counters are enabled by defining
// MULTI_CYCLE_CTRL_PERF_EN (adds cycle_cnt and instr_cnt ports).
module multi_cycle_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  Opcode,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        ALUSrc,
  output logic        Jal,
  output logic        Jalr,
  output logic [1:0]  ALUOp,
  output logic [2:0]  state_o,
  output logic        halted,
  output logic        error
`ifdef MULTI_CYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  mc_state_e  r_state;
  mc_state_e  w_state_next;
  logic [6:0] r_op_q;
  logic       w_timeout;
  logic       w_state_chg;

  assign w_state_chg = (w_state_next != r_state);

  mc_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk         (clk),
    .reset       (reset),
    .i_mem_req   (mem_req),
    .i_mem_ready (mem_ready),
    .i_state_chg (w_state_chg),
    .o_timeout   (w_timeout)
  );

  // State register and opcode latch; reset wins from any state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_FETCH;
      r_op_q  <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_DECODE) begin
        r_op_q <= Opcode;
      end
    end
  end

  // Next-state and output decode; everything stays low while reset is low.
  always_comb begin
    w_state_next = r_state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    IorD         = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    PCWriteCond  = 1'b0;
    RegWrite     = 1'b0;
    MemtoReg     = 1'b0;
    ALUSrc       = 1'b0;
    Jal          = 1'b0;
    Jalr         = 1'b0;
    ALUOp        = ALUOP_MEM;
    state_o      = 3'd0;
    halted       = 1'b0;
    error        = 1'b0;
    if (reset) begin
      state_o = r_state;
      case (r_state)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            IRWrite      = 1'b1;
            PCWrite      = 1'b1;
            w_state_next = ST_DECODE;
          end else if (w_timeout) begin
            w_state_next = ST_ERR;
          end
        end
        ST_DECODE: begin
          if (Opcode == OP_HALT) begin
            w_state_next = ST_HALTED;
          end else if (!is_exec_op(Opcode)) begin
            w_state_next = ST_ERR;
          end else begin
            w_state_next = ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (r_op_q)
            OP_LOAD, OP_STORE: begin
              ALUSrc       = 1'b1;
              ALUOp        = ALUOP_MEM;
              w_state_next = ST_MEM;
            end
            OP_BRANCH: begin
              ALUOp        = ALUOP_BR;
              PCWriteCond  = 1'b1;
              w_state_next = ST_FETCH;
            end
            OP_RTYPE: begin
              ALUOp        = ALUOP_ARITH;
              w_state_next = ST_WB;
            end
            OP_OPIMM, OP_JAL, OP_JALR: begin
              ALUSrc       = 1'b1;
              ALUOp        = ALUOP_ARITH;
              w_state_next = ST_WB;
            end
            OP_LUI: begin
              ALUSrc       = 1'b1;
              ALUOp        = ALUOP_UTYPE;
              w_state_next = ST_WB;
            end
            // DECODE filters illegal opcodes; anything else is corruption.
            default: w_state_next = ST_ERR;
          endcase
        end
        ST_MEM: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
          mem_we  = (r_op_q == OP_STORE);
          if (mem_ready) begin
            w_state_next = (r_op_q == OP_LOAD) ? ST_WB : ST_FETCH;
          end else if (w_timeout) begin
            w_state_next = ST_ERR;
          end
        end
        ST_WB: begin
          RegWrite     = 1'b1;
          MemtoReg     = (r_op_q == OP_LOAD);
          Jal          = (r_op_q == OP_JAL);
          Jalr         = (r_op_q == OP_JALR);
          PCWrite      = (r_op_q == OP_JAL) || (r_op_q == OP_JALR);
          w_state_next = ST_FETCH;
        end
        ST_HALTED: halted = 1'b1;
        ST_ERR:    error  = 1'b1;
        default:   w_state_next = ST_ERR;
      endcase
    end
  end

`ifdef MULTI_CYCLE_CTRL_PERF_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;

  // Active-cycle and retired-decode counters, both wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if ((r_state != ST_HALTED) && (r_state != ST_ERR)) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
      if ((r_state == ST_DECODE) && (w_state_next == ST_EXEC)) begin
        r_instr_cnt <= r_instr_cnt + 32'd1;
      end
    end
  end

  assign cycle_cnt = reset ? r_cycle_cnt : 32'd0;
  assign instr_cnt = reset ? r_instr_cnt : 32'd0;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed testbench for multi_cycle_ctrl (built with MEM_TIMEOUT=4).
// Perf-counter checks are included when MULTI_CYCLE_CTRL_PERF_EN is defined.
module tb_multi_cycle_ctrl;

  localparam int unsigned TB_TIMEOUT = 4;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_HALT = 7'b0000001;

  // Bit positions inside the packed output vector 'outs'.
  localparam logic [14:0] B_MREQ = 15'h4000;
  localparam logic [14:0] B_MWE  = 15'h2000;
  localparam logic [14:0] B_IORD = 15'h1000;
  localparam logic [14:0] B_IRW  = 15'h0800;
  localparam logic [14:0] B_PCW  = 15'h0400;
  localparam logic [14:0] B_PCWC = 15'h0200;
  localparam logic [14:0] B_RW   = 15'h0100;
  localparam logic [14:0] B_M2R  = 15'h0080;
  localparam logic [14:0] B_ASRC = 15'h0040;
  localparam logic [14:0] B_JAL  = 15'h0020;
  localparam logic [14:0] B_JALR = 15'h0010;
  localparam logic [14:0] ALU01  = 15'h0004;
  localparam logic [14:0] ALU10  = 15'h0008;
  localparam logic [14:0] ALU11  = 15'h000C;
  localparam logic [14:0] B_HALT = 15'h0002;
  localparam logic [14:0] B_ERR  = 15'h0001;
  localparam logic [14:0] F_DONE = 15'h4C00; // mem_req | IRWrite | PCWrite

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  Opcode;
  logic        mem_ready;
  logic        mem_req, mem_we, IorD, IRWrite, PCWrite, PCWriteCond;
  logic        RegWrite, MemtoReg, ALUSrc, Jal, Jalr;
  logic [1:0]  ALUOp;
  logic [2:0]  state_o;
  logic        halted, error;
`ifdef MULTI_CYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif
  logic [14:0] outs;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign outs = {mem_req, mem_we, IorD, IRWrite, PCWrite, PCWriteCond, RegWrite,
                 MemtoReg, ALUSrc, Jal, Jalr, ALUOp, halted, error};

  multi_cycle_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .Opcode      (Opcode),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .IorD        (IorD),
    .IRWrite     (IRWrite),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .RegWrite    (RegWrite),
    .MemtoReg    (MemtoReg),
    .ALUSrc      (ALUSrc),
    .Jal         (Jal),
    .Jalr        (Jalr),
    .ALUOp       (ALUOp),
    .state_o     (state_o),
    .halted      (halted),
    .error       (error)
`ifdef MULTI_CYCLE_CTRL_PERF_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instr_cnt   (instr_cnt)
`endif
  );

  // Two reset edges, then release; returns 1 time unit after a rising edge.
  task automatic do_reset();
    reset     = 1'b0;
    mem_ready = 1'b0;
    Opcode    = 7'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    mem_ready = 1'b1;
    Opcode    = OP_ADDI;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (state_o !== 3'd0 || outs !== 15'h0) begin
      failures++;
      $display("FAIL reset_hold state=%0d outs=%h exp state=0 outs=0000", state_o, outs);
    end
    reset     = 1'b1;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state_o !== 3'd0 || outs !== B_MREQ) begin
      failures++;
      $display("FAIL reset_release state=%0d outs=%h exp state=0 outs=%h", state_o, outs, B_MREQ);
    end
`ifdef MULTI_CYCLE_CTRL_PERF_EN
    checks++;
    if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_perf cycle_cnt=%0d instr_cnt=%0d exp 0 0", cycle_cnt, instr_cnt);
    end
`endif
  endtask

  task automatic test_addi();
    logic [2:0]  es [5];
    logic [14:0] eo [5];
    logic        rd [5];
    es = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    eo = '{F_DONE, 15'h0, B_ASRC | ALU10, B_RW, B_MREQ};
    rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    Opcode = OP_ADDI;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rd[i];
      #1;
      checks++;
      if (state_o !== es[i] || outs !== eo[i]) begin
        failures++;
        $display("FAIL addi cyc%0d state=%0d outs=%h exp state=%0d outs=%h", i, state_o, outs, es[i], eo[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    logic [2:0]  es [9];
    logic [14:0] eo [9];
    logic        rd [9];
    es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    eo = '{F_DONE, 15'h0, B_ASRC, B_MREQ | B_IORD, B_MREQ | B_IORD, B_MREQ | B_IORD,
           B_MREQ | B_IORD, B_RW | B_M2R, B_MREQ};
    rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    Opcode = OP_LW;
    for (int i = 0; i < 9; i++) begin
      mem_ready = rd[i];
      #1;
      checks++;
      if (state_o !== es[i] || outs !== eo[i]) begin
        failures++;
        $display("FAIL lw_wait cyc%0d state=%0d outs=%h exp state=%0d outs=%h", i, state_o, outs, es[i], eo[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_branch();
    logic [2:0]  es [9];
    logic [14:0] eo [9];
    logic        rd [9];
    // SW zero-wait (cycles 0..3), back at FETCH on 4, then a branch (4..7).
    es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0};
    eo = '{F_DONE, 15'h0, B_ASRC, B_MREQ | B_MWE | B_IORD, F_DONE, 15'h0,
           B_PCWC | ALU01, B_MREQ, B_MREQ};
    rd = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      mem_ready = rd[i];
      Opcode    = (i < 4) ? OP_SW : OP_BR;
      #1;
      checks++;
      if (state_o !== es[i] || outs !== eo[i]) begin
        failures++;
        $display("FAIL sw_br cyc%0d state=%0d outs=%h exp state=%0d outs=%h", i, state_o, outs, es[i], eo[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_ops();
    logic [6:0]  ops [4];
    logic [14:0] ex  [4];
    logic [14:0] wb  [4];
    ops = '{OP_R, OP_LUI, OP_JAL, OP_JALR};
    ex  = '{ALU10, B_ASRC | ALU11, B_ASRC | ALU10, B_ASRC | ALU10};
    wb  = '{B_RW, B_RW, B_RW | B_JAL | B_PCW, B_RW | B_JALR | B_PCW};
    for (int k = 0; k < 4; k++) begin
      do_reset();
      Opcode    = ops[k];
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(posedge clk); #1;
      #1;
      checks++;
      if (state_o !== 3'd2 || outs !== ex[k]) begin
        failures++;
        $display("FAIL alu_exec op%0d state=%0d outs=%h exp state=2 outs=%h", k, state_o, outs, ex[k]);
      end
      @(posedge clk); #1;
      checks++;
      if (state_o !== 3'd4 || outs !== wb[k]) begin
        failures++;
        $display("FAIL alu_wb op%0d state=%0d outs=%h exp state=4 outs=%h", k, state_o, outs, wb[k]);
      end
      @(posedge clk); #1;
      checks++;
      if (state_o !== 3'd0 || outs !== B_MREQ) begin
        failures++;
        $display("FAIL alu_refetch op%0d state=%0d outs=%h exp state=0 outs=%h", k, state_o, outs, B_MREQ);
      end
    end
  endtask

  task automatic test_timeout();
    logic [2:0]  es [8];
    logic [14:0] eo [8];
    logic        rd [8];
    es = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd6, 3'd6};
    eo = '{B_MREQ, B_MREQ, B_MREQ, B_MREQ, B_MREQ, B_ERR, B_ERR, B_ERR};
    rd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    Opcode = OP_ADDI;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rd[i];
      #1;
      checks++;
      if (state_o !== es[i] || outs !== eo[i]) begin
        failures++;
        $display("FAIL timeout cyc%0d state=%0d outs=%h exp state=%0d outs=%h", i, state_o, outs, es[i], eo[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ready_wins();
    logic [2:0]  es [9];
    logic [14:0] eo [9];
    logic        rd [9];
    es = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    eo = '{B_MREQ, B_MREQ, B_MREQ, B_MREQ, F_DONE, 15'h0, B_ASRC | ALU10, B_RW, B_MREQ};
    rd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    Opcode = OP_ADDI;
    for (int i = 0; i < 9; i++) begin
      mem_ready = rd[i];
      #1;
      checks++;
      if (state_o !== es[i] || outs !== eo[i]) begin
        failures++;
        $display("FAIL ready_wins cyc%0d state=%0d outs=%h exp state=%0d outs=%h", i, state_o, outs, es[i], eo[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal_and_halt();
    // Illegal opcode: FETCH, DECODE, then absorbed in ERR.
    do_reset();
    Opcode    = 7'b1111111;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      mem_ready = i[0];
      #1;
      checks++;
      if (state_o !== 3'd6 || outs !== B_ERR) begin
        failures++;
        $display("FAIL illegal cyc%0d state=%0d outs=%h exp state=6 outs=%h", i, state_o, outs, B_ERR);
      end
      @(posedge clk); #1;
    end
    // HALT opcode: HALTED after DECODE, mem_req stays low for 20 cycles.
    do_reset();
    Opcode    = OP_HALT;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state_o !== 3'd1 || outs !== 15'h0) begin
      failures++;
      $display("FAIL halt_decode state=%0d outs=%h exp state=1 outs=0000", state_o, outs);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 21; i++) begin
      mem_ready = i[0];
      Opcode    = OP_ADDI;
      #1;
      checks++;
      if (state_o !== 3'd5 || outs !== B_HALT) begin
        failures++;
        $display("FAIL halted cyc%0d state=%0d outs=%h exp state=5 outs=%h", i, state_o, outs, B_HALT);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [2:0]  es [6];
    do_reset();
    Opcode    = OP_SW;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Three unacknowledged cycles in MEM leave the wait counter at 3.
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (state_o !== 3'd3 || outs !== (B_MREQ | B_MWE | B_IORD)) begin
        failures++;
        $display("FAIL sw_mem cyc%0d state=%0d outs=%h exp state=3 outs=%h", i, state_o, outs, B_MREQ | B_MWE | B_IORD);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    checks++;
    if (state_o !== 3'd0 || outs !== 15'h0) begin
      failures++;
      $display("FAIL mid_mem_forced state=%0d outs=%h exp state=0 outs=0000", state_o, outs);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state_o !== 3'd0 || outs !== 15'h0 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL mid_mem_held state=%0d outs=%h exp state=0 outs=0000", state_o, outs);
    end
    @(posedge clk); #1;
    reset     = 1'b1;
    mem_ready = 1'b0;
    // A fresh wait count must start from zero: ERR only after 5 FETCH cycles.
    es = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6};
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (state_o !== es[i]) begin
        failures++;
        $display("FAIL post_reset_wait cyc%0d state=%0d exp state=%0d", i, state_o, es[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_st;
    do_reset();
    Opcode = OP_ADDI;
    for (int i = 0; i < 13; i++) begin
      mem_ready = ((i % 4) == 0) && (i < 12);
      case (i % 4)
        0:       exp_st = 3'd0;
        1:       exp_st = 3'd1;
        2:       exp_st = 3'd2;
        default: exp_st = 3'd4;
      endcase
      #1;
      checks++;
      if (state_o !== exp_st) begin
        failures++;
        $display("FAIL b2b cyc%0d state=%0d exp state=%0d", i, state_o, exp_st);
      end
`ifdef MULTI_CYCLE_CTRL_PERF_EN
      if (i == 12) begin
        checks++;
        if (instr_cnt !== 32'd3 || cycle_cnt !== 32'd12) begin
          failures++;
          $display("FAIL perf_cnt instr_cnt=%0d cycle_cnt=%0d exp 3 12", instr_cnt, cycle_cnt);
        end
      end
`endif
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset     = 1'b0;
    mem_ready = 1'b0;
    Opcode    = 7'd0;
    test_reset();
    test_addi();
    test_lw_wait();
    test_sw_branch();
    test_alu_ops();
    test_timeout();
    test_ready_wins();
    test_illegal_and_halt();
    test_reset_mid_mem();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog run did not complete checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, memory wait cycles tolerated before ERR (legal range 1..255).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 Opcode  in  7  opcode field of the instruction register.
REQ-005 mem_ready  in  1  memory completion strobe; ignored while mem_req=0.
REQ-006 mem_req  out  1  memory access request.
REQ-007 mem_we  out  1  1 = store access.
REQ-008 IorD  out  1  0 = memory address from PC; 1 = address from ALU result.
REQ-009 IRWrite, PCWrite, PCWriteCond, RegWrite, MemtoReg, ALUSrc, Jal, Jalr  out  1 each  datapath enables and selects.
REQ-010 ALUOp  out  2  00 LW/SW, 01 branch, 10 R/I/JALR, 11 U-type.
REQ-011 state_o  out  3  current state encoding; halted, error  out  1 each, sticky status.

Function
REQ-012 Seven states: FETCH, DECODE, EXEC, MEM, WB, HALTED, ERR; all outputs are combinational decodes of state and op_q.
REQ-013 FETCH: mem_req=1, IorD=0, mem_we=0; on mem_ready=1, IRWrite=1, PCWrite=1 (PC+4) in that cycle, then DECODE.
REQ-014 DECODE: Opcode latched into op_q; next state HALTED if 0000001, ERR if not one of 0110011, 0000011, 0100011, 1100011, 0010011, 0110111, 1101111, 1100111; else EXEC.
REQ-015 EXEC: ALUSrc and ALUOp driven per op_q; LW/SW -> MEM; BR -> PCWriteCond=1 for one cycle, then FETCH; all other opcodes -> WB.
REQ-016 MEM: mem_req=1, IorD=1, mem_we=(op_q==SW); on mem_ready, LW -> WB and SW -> FETCH.
REQ-017 WB: RegWrite=1 for exactly one cycle, MemtoReg=(op_q==LW); JAL/JALR additionally assert Jal/Jalr and PCWrite; then FETCH.
REQ-018 mem_req, mem_we and IorD held constant from request until the cycle mem_ready is sampled high; a zero-wait access (mem_ready in the first request cycle) completes in that cycle.
REQ-019 Latency: R/I/U/JAL/JALR = 4 cycles, BR = 3, SW = 4, LW = 5, each with zero memory wait states.
REQ-020 Wait counter increments each cycle mem_req=1 and mem_ready=0; it clears on mem_ready and on every state change; it saturates at 8 bits.
REQ-021 Counter reaching MEM_TIMEOUT while mem_ready=0 -> ERR next cycle; mem_ready in that same cycle wins and completes normally.
REQ-022 HALTED and ERR are absorbing; only reset exits; all enables are 0 there; halted=1 in HALTED; error=1 in ERR.

Reset
REQ-023 reset=0 at a clock edge -> state=FETCH, op_q=0, wait counter=0, perf counters=0, regardless of current state including mid-access.
REQ-024 While reset=0 every output is forced to 0; first FETCH request appears in the cycle after reset returns high.

Configuration
REQ-025 Macro MULTI_CYCLE_CTRL_PERF_EN defined: adds outputs cycle_cnt[31:0], counting every non-reset cycle outside HALTED/ERR, and instr_cnt[31:0], incrementing on each DECODE->EXEC transition; both wrap modulo 2^32.
REQ-026 Macro undefined: both ports and their counters are absent; all other behaviour is identical.

Structure
REQ-027 Package mc_pkg holds the state enum, the nine opcode constants and the ALUOp encodings; the module imports it.
REQ-028 One sub-module, mc_wait_timer, implements the wait counter and timeout compare.

Verification
REQ-029 ADDI (0010011), zero wait -> states FETCH, DECODE, EXEC, WB, FETCH; RegWrite high exactly 1 cycle; ALUOp=10; ALUSrc=1.
REQ-030 LW with mem_ready delayed 3 cycles in MEM -> mem_req/IorD=1 held for 4 cycles; then WB with MemtoReg=1; total 8 cycles.
REQ-031 MEM_TIMEOUT=4, mem_ready never asserted in FETCH -> ERR after 5 cycles; error=1; all enables 0 until reset.
REQ-032 Opcode 0000001 -> HALTED after DECODE; halted=1; mem_req stays 0 for 20 further cycles.
REQ-033 reset=0 asserted mid-MEM of SW -> next cycle state_o=FETCH encoding, mem_we=0, all outputs 0 while reset=0.
REQ-034 PERF_EN build, 3 ADDIs executed -> instr_cnt=3, cycle_cnt=12 at the 4th FETCH entry.
